dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port, byte-enabled data-memory BRAM between two requesters: the CPU load/store stage (port c) and a DMA/bridge master (port d).
- CPU has fixed priority, bounded by an anti-starvation counter.
- Generates byte-lane enables and lane-replicated write data for sb/sh/sw.
- Tracks the RAM's 1-cycle read latency and returns lb/lbu/lh/lhu/lw data, extended, to the requester that issued the read.

Parameters:
ADDR_W, 13, RAM word-index width; ram_addr = addr[ADDR_W+1:2]
STARVE_MAX, 4, consecutive CPU grants allowed while port d waits before d is forced through (>=1)

Ports:
clk  in  1  clock, rising edge
clr_n  in  1  asynchronous active-low reset
c_req  in  1  CPU access request
c_we  in  1  1=store, 0=load
c_size  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word)
c_sext  in  1  sign-extend load result
c_addr  in  32  byte address
c_wd  in  32  store data, right-aligned
c_gnt  out  1  request accepted this cycle
c_aerr  out  1  misaligned request accepted and dropped (pulse, same cycle as c_gnt)
c_rvalid  out  1  load data valid
c_rdata  out  32  extended load data
d_req, d_we, d_size, d_sext, d_addr, d_wd, d_gnt, d_aerr, d_rvalid, d_rdata: same as the c_ ports, for port d
ram_en  out  1  RAM access this cycle
ram_we  out  4  per-byte write enables, already gated by store
ram_addr  out  ADDR_W  word index
ram_wd  out  32  lane-replicated write data
ram_rd  in  32  RAM read data, valid one cycle after the read cycle

Behaviour:
- Reset (clr_n=0, asynchronous):
  - Clears starve_cnt and the read pipeline register (rd_v, rd_own, rd_size, rd_sext, rd_off).
  - While reset is held, all grants, aerr, rvalid, ram_en and ram_we are 0.
  - All data outputs are 0 while rvalid=0.
- Arbitration (combinational, same cycle):
  - If only one port requests, it wins.
  - If both request, c wins unless starve_cnt==STARVE_MAX; then d wins.
  - Exactly one gnt per cycle, at most. The winner's request is consumed at the next rising edge.
  - The arbiter accepts a new request every cycle, including back-to-back read after read and write after read.
- starve_cnt:
  - Increments when c is granted while d_req=1.
  - Clears when d is granted, or when d_req=0.
  - Saturates at STARVE_MAX.
- Alignment:
  - A half access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]!=0 is misaligned.
  - A misaligned winner gets gnt=1 and aerr=1. ram_en=0, ram_we=0, no rvalid follows, and starve_cnt updates as a normal grant.
- Store lanes:
  - byte: ram_we = 1<<addr[1:0]; ram_wd = {4{wd[7:0]}}
  - half: ram_we = addr[1] ? 1100 : 0011; ram_wd = {2{wd[15:0]}}
  - word: ram_we = 1111; ram_wd = wd
- Loads:
  - In the grant cycle T: ram_en=1, ram_we=0, and the pipeline register captures owner, size, sext and addr[1:0].
  - In cycle T+1: the owner's rvalid=1. rdata is extracted from ram_rd at the captured offset and zero/sign-extended per size and sext (word ignores sext).
  - The non-owner's rvalid stays 0.
- Stores produce no rvalid; gnt is the completion.
- A store at T followed by a load of the same address at T+1 returns the new data (the RAM write completes at the T edge).
- Reset mid-read: if clr_n falls between T and T+1, no rvalid is produced.
- ram_addr and ram_wd are don't-care when ram_en=0; drive them from the winner or 0.

Decomposition:
- Package dm_pkg:
  - Size encodings: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - Owner encodings: OWN_C=1'b0, OWN_D=1'b1.
  - Function misaligned(size, addr[1:0]).
- One sub-module, dm_lane_ext:
  - Combinational load extractor.
  - Inputs: ram_rd, off[1:0], size, sext. Output: rdata[31:0].
  - One instance, shared; its output is routed to c_rdata or d_rdata by rd_own.
- Store lane logic and arbitration stay in dm_arbiter.

Test Plan:
- Reset: hold clr_n=0 with c_req=d_req=1 -> gnts, ram_en, rvalids all 0. Release -> c_gnt=1 on the first cycle.
- CPU sb addr=0x6 wd=0x123456AB -> ram_we=0100, ram_addr=1, ram_wd=0xABABABAB. Next, lb sext=1 addr=0x6 -> c_rvalid at T+1, c_rdata=0xFFFFFFAB. lbu -> 0x000000AB.
- CPU sh addr=0x2 wd=0x00008001 -> ram_we=1100, ram_wd=0x80018001. lh -> 0xFFFF8001. lhu -> 0x00008001. lw addr=0x0 -> 0x8001xxxx, with the low half holding the prior contents.
- Misaligned d lw addr=0x5 and c sh addr=0x3 -> gnt=1, aerr=1, ram_en=0, no rvalid in the following cycle.
- Continuous c_req=d_req=1 loads, STARVE_MAX=4 -> grant sequence C,C,C,C,D,C,C,C,C,D. Each rvalid appears one cycle after its grant on the correct port only.
- Reset mid-read: d lw granted at T, clr_n pulsed low before the T+1 edge -> d_rvalid stays 0. After release, c lw works normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the data-memory arbiter.
// Access sizes, requester identities and the alignment rule.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Size 2'b11 falls into the word case on purpose.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic result;
        case (size)
            SZ_B:    result = 1'b0;
            SZ_H:    result = off[0];
            default: result = (off != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load extractor: picks the addressed byte or half out of a RAM word.
// It then zero- or sign-extends that value to 32 bits.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [31:0] ram_rd,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = ram_rd[{off, 3'b000} +: 8];
        half_v = off[1] ? ram_rd[31:16] : ram_rd[15:0];
        case (size)
            SZ_B:    rdata = {{24{sext & byte_v[7]}}, byte_v};
            SZ_H:    rdata = {{16{sext & half_v[15]}}, half_v};
            default: rdata = ram_rd;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port, byte-enabled data BRAM.
// The CPU has priority, bounded by a starvation counter for port d.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic              c_sext,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wd,
    output logic              c_gnt,
    output logic              c_aerr,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_sext,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wd,
    output logic              d_gnt,
    output logic              d_aerr,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wd,
    input  logic [31:0]       ram_rd
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;
    logic          rd_v_q, rd_v_d;
    logic          rd_own_q, rd_own_d;
    logic [1:0]    rd_size_q, rd_size_d;
    logic          rd_sext_q, rd_sext_d;
    logic [1:0]    rd_off_q, rd_off_d;

    logic          c_win, d_win, any_win, mis;
    logic          sel_we, sel_sext;
    logic [1:0]    sel_size;
    logic [31:0]   sel_addr, sel_wd;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wd;
    logic [31:0]   ext_data;
    logic          unused_addr_bits;

    // Grants are gated by clr_n so nothing reaches the RAM while reset is held.
    always_comb begin
        c_win    = clr_n & c_req & ~(d_req & (starve_q == STARVE_LIM));
        d_win    = clr_n & d_req & ~c_win;
        any_win  = c_win | d_win;
        sel_we   = d_win ? d_we   : c_we;
        sel_size = d_win ? d_size : c_size;
        sel_sext = d_win ? d_sext : c_sext;
        sel_addr = d_win ? d_addr : c_addr;
        sel_wd   = d_win ? d_wd   : c_wd;
        mis      = misaligned(sel_size, sel_addr[1:0]);
    end

    always_comb begin
        case (sel_size)
            SZ_B: begin
                lane_we = 4'b0001 << sel_addr[1:0];
                lane_wd = {4{sel_wd[7:0]}};
            end
            SZ_H: begin
                lane_we = sel_addr[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{sel_wd[15:0]}};
            end
            default: begin
                lane_we = 4'b1111;
                lane_wd = sel_wd;
            end
        endcase
    end

    always_comb begin
        c_gnt    = c_win;
        d_gnt    = d_win;
        c_aerr   = c_win & mis;
        d_aerr   = d_win & mis;
        ram_en   = any_win & ~mis;
        ram_we   = (ram_en & sel_we) ? lane_we : 4'b0000;
        ram_addr = any_win ? sel_addr[ADDR_W+1:2] : '0;
        ram_wd   = (any_win & sel_we) ? lane_wd : 32'h0;
    end

    assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

    // A misaligned grant still counts toward starvation like any other grant.
    always_comb begin
        starve_d = starve_q;
        if (!d_req || d_win) begin
            starve_d = '0;
        end else if (c_win && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
        rd_v_d    = ram_en & ~sel_we;
        rd_own_d  = d_win ? OWN_D : OWN_C;
        rd_size_d = sel_size;
        rd_sext_d = sel_sext;
        rd_off_d  = sel_addr[1:0];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            starve_q  <= '0;
            rd_v_q    <= 1'b0;
            rd_own_q  <= OWN_C;
            rd_size_q <= SZ_B;
            rd_sext_q <= 1'b0;
            rd_off_q  <= 2'b00;
        end else begin
            starve_q  <= starve_d;
            rd_v_q    <= rd_v_d;
            rd_own_q  <= rd_own_d;
            rd_size_q <= rd_size_d;
            rd_sext_q <= rd_sext_d;
            rd_off_q  <= rd_off_d;
        end
    end

    dm_lane_ext u_lane_ext (
        .ram_rd (ram_rd),
        .off    (rd_off_q),
        .size   (rd_size_q),
        .sext   (rd_sext_q),
        .rdata  (ext_data)
    );

    always_comb begin
        c_rvalid = rd_v_q & (rd_own_q == OWN_C);
        d_rvalid = rd_v_q & (rd_own_q == OWN_D);
        c_rdata  = c_rvalid ? ext_data : 32'h0;
        d_rdata  = d_rvalid ? ext_data : 32'h0;
    end

endmodule
